// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core: multicycle MIPS32 integer-subset CPU, little-endian.
// One Avalon-MM style master port is shared by instruction fetch and data access.
// States: FETCH -> EXEC -> (MEM -> (WB)) -> FETCH. The core halts when the next fetch address is 0.
// Optional feature macro: MIPS_SUBWORD_LS_EN adds LB/LBU/LH/LHU/SB/SH.
module mips_cpu_bus_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc, r_npc, r_ir, r_mdr;
    logic        r_active, r_read, r_write;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_gpr [32];
`ifdef MIPS_SUBWORD_LS_EN
    logic [1:0]  r_ea_lo;
`endif

    // Instruction fields
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh;
    logic [15:0] w_imm;
    logic [25:0] w_idx;
    logic [31:0] w_rs_val, w_rt_val, w_simm, w_zimm, w_link, w_btgt, w_ea;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_sh     = r_ir[10:6];
    assign w_fn     = r_ir[5:0];
    assign w_imm    = r_ir[15:0];
    assign w_idx    = r_ir[25:0];
    assign w_rs_val = r_gpr[w_rs];
    assign w_rt_val = r_gpr[w_rt];
    assign w_simm   = {{16{w_imm[15]}}, w_imm};
    assign w_zimm   = {16'h0000, w_imm};
    assign w_link   = r_npc + 32'd4;                      // branch PC + 8
    assign w_btgt   = r_npc + {w_simm[29:0], 2'b00};      // relative to delay-slot PC
    assign w_ea     = w_rs_val + w_simm;

    // Decode outputs
    logic [31:0] w_res, w_target, w_wd, w_ld_val;
    logic [4:0]  w_wa;
    logic [3:0]  w_be;
    logic        w_we, w_taken, w_is_ld, w_is_st;

    // Decode IR: ALU result, register write, branch decision, memory access setup
    always_comb begin
        w_res    = 32'd0;
        w_we     = 1'b0;
        w_wa     = 5'd0;
        w_taken  = 1'b0;
        w_target = w_btgt;
        w_is_ld  = 1'b0;
        w_is_st  = 1'b0;
        w_be     = 4'hF;
        w_wd     = w_rt_val;
        case (w_op)
            6'h00: begin
                w_wa = w_rd;
                case (w_fn)
                    6'h00: begin w_we = 1'b1; w_res = w_rt_val << w_sh; end
                    6'h02: begin w_we = 1'b1; w_res = w_rt_val >> w_sh; end
                    6'h03: begin w_we = 1'b1; w_res = $signed(w_rt_val) >>> w_sh; end
                    6'h04: begin w_we = 1'b1; w_res = w_rt_val << w_rs_val[4:0]; end
                    6'h06: begin w_we = 1'b1; w_res = w_rt_val >> w_rs_val[4:0]; end
                    6'h07: begin w_we = 1'b1; w_res = $signed(w_rt_val) >>> w_rs_val[4:0]; end
                    6'h08: begin w_taken = 1'b1; w_target = w_rs_val; end
                    6'h09: begin w_taken = 1'b1; w_target = w_rs_val; w_we = 1'b1; w_res = w_link; end
                    6'h21: begin w_we = 1'b1; w_res = w_rs_val + w_rt_val; end
                    6'h23: begin w_we = 1'b1; w_res = w_rs_val - w_rt_val; end
                    6'h24: begin w_we = 1'b1; w_res = w_rs_val & w_rt_val; end
                    6'h25: begin w_we = 1'b1; w_res = w_rs_val | w_rt_val; end
                    6'h26: begin w_we = 1'b1; w_res = w_rs_val ^ w_rt_val; end
                    6'h27: begin w_we = 1'b1; w_res = ~(w_rs_val | w_rt_val); end
                    6'h2A: begin w_we = 1'b1; w_res = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)}; end
                    6'h2B: begin w_we = 1'b1; w_res = {31'd0, w_rs_val < w_rt_val}; end
                    default: w_we = 1'b0;
                endcase
            end
            6'h01: begin
                case (w_rt)
                    5'h00:   w_taken = w_rs_val[31];
                    5'h01:   w_taken = ~w_rs_val[31];
                    default: w_taken = 1'b0;
                endcase
            end
            6'h02: begin w_taken = 1'b1; w_target = {r_npc[31:28], w_idx, 2'b00}; end
            6'h03: begin
                w_taken = 1'b1; w_target = {r_npc[31:28], w_idx, 2'b00};
                w_we = 1'b1; w_wa = 5'd31; w_res = w_link;
            end
            6'h04: w_taken = (w_rs_val == w_rt_val);
            6'h05: w_taken = (w_rs_val != w_rt_val);
            6'h06: w_taken = w_rs_val[31] | (w_rs_val == 32'd0);
            6'h07: w_taken = ~w_rs_val[31] & (w_rs_val != 32'd0);
            6'h09: begin w_we = 1'b1; w_wa = w_rt; w_res = w_rs_val + w_simm; end
            6'h0A: begin w_we = 1'b1; w_wa = w_rt; w_res = {31'd0, $signed(w_rs_val) < $signed(w_simm)}; end
            6'h0B: begin w_we = 1'b1; w_wa = w_rt; w_res = {31'd0, w_rs_val < w_simm}; end
            6'h0C: begin w_we = 1'b1; w_wa = w_rt; w_res = w_rs_val & w_zimm; end
            6'h0D: begin w_we = 1'b1; w_wa = w_rt; w_res = w_rs_val | w_zimm; end
            6'h0E: begin w_we = 1'b1; w_wa = w_rt; w_res = w_rs_val ^ w_zimm; end
            6'h0F: begin w_we = 1'b1; w_wa = w_rt; w_res = {w_imm, 16'h0000}; end
            6'h23: w_is_ld = 1'b1;
            6'h2B: w_is_st = 1'b1;
`ifdef MIPS_SUBWORD_LS_EN
            6'h20, 6'h24: begin w_is_ld = 1'b1; w_be = 4'b0001 << w_ea[1:0]; end
            6'h21, 6'h25: begin w_is_ld = 1'b1; w_be = w_ea[1] ? 4'b1100 : 4'b0011; end
            6'h28: begin w_is_st = 1'b1; w_be = 4'b0001 << w_ea[1:0]; w_wd = {4{w_rt_val[7:0]}}; end
            6'h29: begin w_is_st = 1'b1; w_be = w_ea[1] ? 4'b1100 : 4'b0011; w_wd = {2{w_rt_val[15:0]}}; end
`endif
            default: w_we = 1'b0;
        endcase
    end

`ifdef MIPS_SUBWORD_LS_EN
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;
    assign w_lbyte = r_mdr[{r_ea_lo, 3'b000} +: 8];
    assign w_lhalf = r_ea_lo[1] ? r_mdr[31:16] : r_mdr[15:0];

    // Extract and extend the addressed lane of the latched load word
    always_comb begin
        case (w_op)
            6'h20:   w_ld_val = {{24{w_lbyte[7]}}, w_lbyte};
            6'h24:   w_ld_val = {24'd0, w_lbyte};
            6'h21:   w_ld_val = {{16{w_lhalf[15]}}, w_lhalf};
            6'h25:   w_ld_val = {16'd0, w_lhalf};
            default: w_ld_val = r_mdr;
        endcase
    end
`else
    assign w_ld_val = r_mdr;
`endif

    // Control FSM: program counters, instruction/data latches and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_VECTOR;
            r_npc    <= RESET_VECTOR + 32'd4;
            r_ir     <= 32'd0;
            r_mdr    <= 32'd0;
            r_active <= 1'b1;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'h0;
`ifdef MIPS_SUBWORD_LS_EN
            r_ea_lo  <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_read) begin
                        r_read <= 1'b1;
                        r_addr <= r_pc;
                        r_be   <= 4'hF;
                    end else if (!waitrequest) begin
                        r_ir    <= readdata;
                        r_read  <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pc  <= r_npc;
                    r_npc <= w_taken ? w_target : (r_npc + 32'd4);
                    if (w_is_ld || w_is_st) begin
                        r_state <= S_MEM;
                        r_read  <= w_is_ld;
                        r_write <= w_is_st;
                        r_addr  <= w_ea & 32'hFFFF_FFFC;
                        r_be    <= w_be;
                        r_wdata <= w_is_st ? w_wd : r_wdata;
`ifdef MIPS_SUBWORD_LS_EN
                        r_ea_lo <= w_ea[1:0];
`endif
                    end else if (r_npc == 32'd0) begin
                        r_state  <= S_HALT;
                        r_active <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_mdr   <= readdata;
                            r_state <= S_WB;
                        end else if (r_pc == 32'd0) begin
                            r_state  <= S_HALT;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (r_pc == 32'd0) begin
                        r_state  <= S_HALT;
                        r_active <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Register file: ALU/link results written in EXEC, load data written in WB; $0 stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'd0;
            end
        end else if ((r_state == S_EXEC) && w_we && (w_wa != 5'd0)) begin
            r_gpr[w_wa] <= w_res;
        end else if ((r_state == S_WB) && (w_rt != 5'd0)) begin
            r_gpr[w_rt] <= w_ld_val;
        end
    end

    assign active      = r_active;
    assign register_v0 = r_gpr[2];
    assign address     = r_addr;
    assign read        = r_read;
    assign write       = r_write;
    assign writedata   = r_wdata;
    assign byteenable  = r_be;

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed bench for mips_cpu_bus_core: a word memory model serves the bus with a
// configurable stall, stores are scored against a queue of expected writes.
module tb_mips_cpu_bus_core;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    mips_cpu_bus_core #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic [31:0] mem [logic [29:0]];
    wr_t         sb [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          g_off, st_off;

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic t_put(input int off, input logic [31:0] w);
        logic [31:0] a;
        a = RV + off;
        mem[a[31:2]] = w;
    endtask

    task automatic t_emit(input logic [31:0] w);
        t_put(g_off, w);
        g_off += 4;
    endtask

    task automatic t_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.a = a; e.d = d; e.be = be;
        sb.push_back(e);
    endtask

    // ALU op into $7, then store $7 at the next result slot of base $3 = 0x1000
    task automatic t_alu(input logic [31:0] w, input logic [31:0] expv);
        t_emit(w);
        t_emit(f_i(6'h2B, 5'd3, 5'd7, st_off[15:0]));
        t_exp(32'h1000 + st_off, expv, 4'hF);
        st_off += 4;
    endtask

    task automatic t_new();
        mem.delete();
        sb.delete();
        g_off = 0;
        st_off = 0;
    endtask

    task automatic t_run(input string tag, input int stall, input logic [31:0] exp_v0);
        int          cnt;
        bit          done;
        logic [31:0] s_addr, s_wd, w;
        logic [5:0]  s_ctl;
        wr_t         e;
        cnt = 0;
        done = 1'b0;
        s_addr = 32'd0; s_wd = 32'd0; s_ctl = 6'd0;
        rst = 1'b1; waitrequest = 1'b0; readdata = 32'd0;
        @(negedge clk); @(negedge clk);
        t_check({tag, ":rst_active"}, {31'd0, active}, 32'd1);
        t_check({tag, ":rst_ctl"}, {26'd0, read, write, byteenable}, 32'd0);
        t_check({tag, ":rst_addr"}, address, 32'd0);
        t_check({tag, ":rst_v0"}, register_v0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        t_check({tag, ":first_read"}, {31'd0, read}, 32'd1);
        t_check({tag, ":first_addr"}, address, RV);
        for (int c = 0; c < 20000 && !done; c++) begin
            if (!active) begin
                done = 1'b1;
            end else if (read || write) begin
                t_check({tag, ":rw_excl"}, {31'd0, read & write}, 32'd0);
                if (cnt > 0) begin
                    t_check({tag, ":stall_addr"}, address, s_addr);
                    t_check({tag, ":stall_wd"}, writedata, s_wd);
                    t_check({tag, ":stall_ctl"}, {26'd0, read, write, byteenable}, {26'd0, s_ctl});
                end
                if (cnt < stall) begin
                    waitrequest = 1'b1;
                    cnt++;
                    s_addr = address; s_wd = writedata; s_ctl = {read, write, byteenable};
                end else begin
                    waitrequest = 1'b0;
                    cnt = 0;
                    if (read) begin
                        readdata = mem.exists(address[31:2]) ? mem[address[31:2]] : 32'd0;
                    end else begin
                        t_check({tag, ":wr_expected"}, {31'd0, sb.size() > 0}, 32'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            t_check({tag, ":wr_addr"}, address, e.a);
                            t_check({tag, ":wr_data"}, writedata, e.d);
                            t_check({tag, ":wr_be"}, {28'd0, byteenable}, {28'd0, e.be});
                        end
                        w = mem.exists(address[31:2]) ? mem[address[31:2]] : 32'd0;
                        for (int b = 0; b < 4; b++) begin
                            if (byteenable[b]) w[8*b +: 8] = writedata[8*b +: 8];
                        end
                        mem[address[31:2]] = w;
                    end
                end
            end else begin
                waitrequest = (stall > 0);
                cnt = 0;
            end
            if (!done) @(negedge clk);
        end
        t_check({tag, ":halted"}, {31'd0, active}, 32'd0);
        t_check({tag, ":v0"}, register_v0, exp_v0);
        t_check({tag, ":idle_bus"}, {30'd0, read, write}, 32'd0);
        t_check({tag, ":sb_drained"}, sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        t_check({tag, ":halt_hold"}, {register_v0[30:0], active}, {exp_v0[30:0], 1'b0});
    endtask

    initial begin
        waitrequest = 1'b0;
        readdata = 32'd0;

        // Halt via JR $0 after its delay slot
        t_new();
        t_emit(f_i(6'h09, 5'd0, 5'd2, 16'h1234));
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("halt", 0, 32'h0000_1234);

        // Same program, every access stalled 5 cycles
        t_new();
        t_emit(f_i(6'h09, 5'd0, 5'd2, 16'h1234));
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("halt_stall", 5, 32'h0000_1234);

        // Store then load back, with and without stalls
        for (int s = 0; s < 6; s += 5) begin
            t_new();
            t_emit(f_i(6'h09, 5'd0, 5'd2, 16'd7));
            t_emit(f_i(6'h09, 5'd0, 5'd3, 16'h1000));
            t_emit(f_i(6'h2B, 5'd3, 5'd2, 16'd0));
            t_exp(32'h1000, 32'd7, 4'hF);
            t_emit(f_i(6'h23, 5'd3, 5'd4, 16'd0));
            t_emit(f_r(5'd4, 5'd4, 5'd2, 5'd0, 6'h21));
            t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
            t_emit(32'd0);
            t_run((s == 0) ? "swlw" : "swlw_stall", s, 32'h0000_000E);
        end

        // BEQ taken: delay slot applied, next instruction skipped
        t_new();
        t_emit(f_i(6'h09, 5'd0, 5'd2, 16'd1));
        t_emit(f_i(6'h04, 5'd0, 5'd0, 16'd2));
        t_emit(f_i(6'h09, 5'd2, 5'd2, 16'h0010));
        t_emit(f_i(6'h09, 5'd2, 5'd2, 16'h0100));
        t_emit(f_i(6'h09, 5'd2, 5'd2, 16'h1000));
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("beq", 0, 32'h0000_1011);

        // ALU coverage, each result stored through the scoreboard ($5=-3, $6=5)
        t_new();
        t_emit(f_i(6'h09, 5'd0, 5'd3, 16'h1000));
        t_emit(f_i(6'h09, 5'd0, 5'd5, 16'hFFFD));
        t_emit(f_i(6'h09, 5'd0, 5'd6, 16'd5));
        t_alu(f_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h23), 32'h0000_0008);          // SUBU
        t_alu(f_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h2A), 32'h0000_0001);          // SLT
        t_alu(f_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h2B), 32'h0000_0000);          // SLTU
        t_alu(f_r(5'd0, 5'd5, 5'd7, 5'd1, 6'h03), 32'hFFFF_FFFE);          // SRA
        t_alu(f_r(5'd0, 5'd5, 5'd7, 5'd28, 6'h02), 32'h0000_000F);         // SRL
        t_alu(f_r(5'd0, 5'd6, 5'd7, 5'd4, 6'h00), 32'h0000_0050);          // SLL
        t_emit(f_i(6'h0F, 5'd0, 5'd7, 16'h8001));                          // LUI
        t_alu(f_i(6'h0D, 5'd7, 5'd7, 16'hF00F), 32'h8001_F00F);            // ORI
        t_alu(f_r(5'd0, 5'd6, 5'd7, 5'd0, 6'h27), 32'hFFFF_FFFA);          // NOR
        t_alu(f_i(6'h0B, 5'd6, 5'd7, 16'hFFFF), 32'h0000_0001);            // SLTIU
        t_alu(f_i(6'h0C, 5'd5, 5'd7, 16'hFF00), 32'h0000_FF00);            // ANDI
        t_alu(f_r(5'd6, 5'd6, 5'd7, 5'd0, 6'h04), 32'h0000_00A0);          // SLLV
        t_alu(f_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h07), 32'hFFFF_FFFF);          // SRAV
        t_alu(f_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h06), 32'h07FF_FFFF);          // SRLV
        t_alu(f_i(6'h0E, 5'd5, 5'd7, 16'h00FF), 32'hFFFF_FF02);            // XORI
        t_alu(f_i(6'h0A, 5'd5, 5'd7, 16'hFFFE), 32'h0000_0001);            // SLTI
        t_alu(f_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h24), 32'h0000_0005);          // AND
        t_alu(f_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h25), 32'hFFFF_FFFD);          // OR
        t_alu(f_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h26), 32'hFFFF_FFF8);          // XOR
        t_alu(f_i(6'h09, 5'd0, 5'd0, 16'd5), 32'h0000_0000);               // ADDIU $0, then SW $7 (= old)
        st_off -= 4; sb.pop_back();
        t_put(g_off - 4, f_i(6'h2B, 5'd3, 5'd0, st_off[15:0]));           // store $0 instead
        t_exp(32'h1000 + st_off, 32'd0, 4'hF);
        st_off += 4;
        t_emit(f_r(5'd5, 5'd6, 5'd2, 5'd0, 6'h21));                        // ADDU
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("alu", 0, 32'h0000_0002);

        // Control flow: BNE loop, JAL link, BLTZ/BGEZ, JALR link, BGTZ/BLEZ
        t_new();
        t_put(32'h00, f_i(6'h09, 5'd0, 5'd3, 16'h1000));
        t_put(32'h04, f_i(6'h09, 5'd0, 5'd2, 16'd0));
        t_put(32'h08, f_i(6'h09, 5'd0, 5'd4, 16'd3));
        t_put(32'h0C, f_i(6'h09, 5'd2, 5'd2, 16'd2));
        t_put(32'h10, f_i(6'h09, 5'd4, 5'd4, 16'hFFFF));
        t_put(32'h14, f_i(6'h05, 5'd4, 5'd0, 16'hFFFD));
        t_put(32'h1C, {6'h03, 26'h3F0_0010});
        t_put(32'h20, f_i(6'h09, 5'd2, 5'd2, 16'd1));
        t_put(32'h24, f_i(6'h09, 5'd2, 5'd2, 16'h0100));
        t_put(32'h40, f_i(6'h2B, 5'd3, 5'd31, 16'd0));
        t_exp(32'h1000, 32'hBFC0_0024, 4'hF);
        t_put(32'h44, f_i(6'h09, 5'd0, 5'd5, 16'hFFFF));
        t_put(32'h48, f_i(6'h01, 5'd5, 5'd0, 16'd3));
        t_put(32'h4C, f_i(6'h09, 5'd2, 5'd2, 16'h0010));
        t_put(32'h50, f_i(6'h09, 5'd2, 5'd2, 16'h0200));
        t_put(32'h58, f_i(6'h01, 5'd5, 5'd1, 16'd2));
        t_put(32'h60, f_i(6'h09, 5'd2, 5'd2, 16'h0020));
        t_put(32'h64, f_i(6'h0F, 5'd0, 5'd6, 16'hBFC0));
        t_put(32'h68, f_i(6'h0D, 5'd6, 5'd6, 16'h0080));
        t_put(32'h6C, f_r(5'd6, 5'd0, 5'd7, 5'd0, 6'h09));
        t_put(32'h74, f_i(6'h09, 5'd2, 5'd2, 16'h0400));
        t_put(32'h80, f_i(6'h2B, 5'd3, 5'd7, 16'd4));
        t_exp(32'h1004, 32'hBFC0_0074, 4'hF);
        t_put(32'h84, f_i(6'h07, 5'd5, 5'd0, 16'd2));
        t_put(32'h8C, f_i(6'h06, 5'd0, 5'd0, 16'd2));
        t_put(32'h90, f_i(6'h09, 5'd2, 5'd2, 16'h0040));
        t_put(32'h94, f_i(6'h09, 5'd2, 5'd2, 16'h0800));
        t_put(32'h98, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_run("ctrl", 2, 32'h0000_0077);

        // Sub-word loads/stores
        t_new();
        t_emit(f_i(6'h09, 5'd0, 5'd3, 16'h1000));
        t_emit(f_i(6'h0F, 5'd0, 5'd7, 16'h80FF));
        t_emit(f_i(6'h0D, 5'd7, 5'd7, 16'h1234));
        t_emit(f_i(6'h2B, 5'd3, 5'd7, 16'd0));
        t_exp(32'h1000, 32'h80FF_1234, 4'hF);
`ifdef MIPS_SUBWORD_LS_EN
        t_emit(f_i(6'h20, 5'd3, 5'd2, 16'd3));
        t_emit(f_i(6'h2B, 5'd3, 5'd2, 16'd4));
        t_exp(32'h1004, 32'hFFFF_FF80, 4'hF);
        t_emit(f_i(6'h24, 5'd3, 5'd2, 16'd2));
        t_emit(f_i(6'h2B, 5'd3, 5'd2, 16'd8));
        t_exp(32'h1008, 32'h0000_00FF, 4'hF);
        t_emit(f_i(6'h21, 5'd3, 5'd2, 16'd2));
        t_emit(f_i(6'h2B, 5'd3, 5'd2, 16'd12));
        t_exp(32'h100C, 32'hFFFF_80FF, 4'hF);
        t_emit(f_i(6'h25, 5'd3, 5'd2, 16'd0));
        t_emit(f_i(6'h2B, 5'd3, 5'd2, 16'd16));
        t_exp(32'h1010, 32'h0000_1234, 4'hF);
        t_emit(f_i(6'h28, 5'd3, 5'd7, 16'd1));
        t_exp(32'h1000, 32'h3434_3434, 4'b0010);
        t_emit(f_i(6'h29, 5'd3, 5'd7, 16'd2));
        t_exp(32'h1000, 32'h1234_1234, 4'b1100);
        t_emit(f_i(6'h23, 5'd3, 5'd2, 16'd0));
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("subword", 1, 32'h1234_3434);
`else
        t_emit(f_i(6'h09, 5'd0, 5'd2, 16'h0055));
        t_emit(f_i(6'h20, 5'd3, 5'd2, 16'd3));
        t_emit(f_i(6'h28, 5'd3, 5'd2, 16'd1));
        t_emit(f_i(6'h25, 5'd3, 5'd2, 16'd0));
        t_emit(f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        t_emit(32'd0);
        t_run("subword_nop", 1, 32'h0000_0055);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
